// File: rtl/spi_engine_arbiter.sv
// Round-robin arbiter sharing one SPI bit engine among NREQ requesters: latches the
// winner's config, pulses eng_start, waits for done under a watchdog, then enforces a CS-high gap.
module spi_engine_arbiter #(
    parameter int NREQ       = 4,
    parameter int MAX_BITS   = 1024,
    parameter int GAP_CYCLES = 4,
    parameter int TIMEOUT    = 4096
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*16-1:0]       req_bits,
    input  logic [NREQ*3-1:0]        req_mode,
    input  logic [NREQ*MAX_BITS-1:0] req_tx,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          ack,
    output logic [NREQ-1:0]          err,
    output logic [MAX_BITS-1:0]      rsp_rx,
    output logic                     eng_start,
    output logic [15:0]              eng_bit_count,
    output logic                     eng_cpol,
    output logic                     eng_cpha,
    output logic                     eng_pfb,
    output logic [MAX_BITS-1:0]      eng_tx_bits,
    input  logic                     eng_busy,
    input  logic                     eng_done,
    input  logic [MAX_BITS-1:0]      eng_rx_bits
);
    localparam int PW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_GAP} state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]         win_q, win_d;
    logic [NREQ-1:0]       gnt_q, gnt_d;
    logic [NREQ-1:0]       ack_q, ack_d;
    logic [NREQ-1:0]       err_q, err_d;
    logic                  start_q, start_d;
    logic [15:0]           bit_count_q, bit_count_d;
    logic [2:0]            mode_q, mode_d;
    logic [MAX_BITS-1:0]   tx_q, tx_d;
    logic [MAX_BITS-1:0]   rsp_rx_q, rsp_rx_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [GW-1:0]         gap_q, gap_d;

    logic [PW-1:0]         win_idx;
    logic                  win_found;
    logic [15:0]           win_bits;
    logic                  win_len_ok;
    int                    cand;

    function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] w);
        ptr_after = (int'(w) == NREQ - 1) ? '0 : w + 1'b1;
    endfunction

    // First pending requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        cand      = 0;
        for (int i = 0; i < NREQ; i++) begin
            cand = int'(rr_ptr_q) + i;
            if (cand >= NREQ) cand = cand - NREQ;
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = PW'(cand);
            end
        end
    end

    assign win_bits   = req_bits[16*win_idx +: 16];
    assign win_len_ok = (win_bits != 16'd0) && (int'(win_bits) <= MAX_BITS);

    always_comb begin
        // NOTE: every next-state signal gets a default before the case so no path infers a latch.
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        win_d       = win_q;
        gnt_d       = gnt_q;
        ack_d       = '0;
        err_d       = '0;
        start_d     = 1'b0;
        bit_count_d = bit_count_q;
        mode_d      = mode_q;
        tx_d        = tx_q;
        rsp_rx_d    = rsp_rx_q;
        timer_d     = timer_q;
        gap_d       = gap_q;

        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    if (win_len_ok) begin
                        bit_count_d    = win_bits;
                        mode_d         = req_mode[3*win_idx +: 3];
                        tx_d           = req_tx[MAX_BITS*win_idx +: MAX_BITS];
                        gnt_d          = '0;
                        gnt_d[win_idx] = 1'b1;
                        win_d          = win_idx;
                        start_d        = 1'b1;
                        timer_d        = '0;
                        state_d        = S_WAIT;
                    end else begin
                        err_d[win_idx] = 1'b1;
                        rr_ptr_d       = ptr_after(win_idx);
                    end
                end
            end
            S_WAIT: begin
                timer_d = timer_q + 1'b1;
                // done takes priority over a coincident watchdog expiry
                if (eng_done) begin
                    rsp_rx_d     = eng_rx_bits;
                    ack_d[win_q] = 1'b1;
                    gap_d        = '0;
                    state_d      = S_GAP;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    err_d[win_q] = 1'b1;
                    gap_d        = '0;
                    state_d      = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q < GW'(GAP_CYCLES - 1)) gap_d = gap_q + 1'b1;
                // a timed-out engine may still be shifting; hold the grant until it idles
                if ((gap_q >= GW'(GAP_CYCLES - 1)) && !eng_busy) begin
                    gnt_d    = '0;
                    rr_ptr_d = ptr_after(win_q);
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            win_q       <= '0;
            gnt_q       <= '0;
            ack_q       <= '0;
            err_q       <= '0;
            start_q     <= 1'b0;
            bit_count_q <= '0;
            mode_q      <= '0;
            tx_q        <= '0;
            rsp_rx_q    <= '0;
            timer_q     <= '0;
            gap_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            win_q       <= win_d;
            gnt_q       <= gnt_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            start_q     <= start_d;
            bit_count_q <= bit_count_d;
            mode_q      <= mode_d;
            tx_q        <= tx_d;
            rsp_rx_q    <= rsp_rx_d;
            timer_q     <= timer_d;
            gap_q       <= gap_d;
        end
    end

    assign gnt           = gnt_q;
    assign ack           = ack_q;
    assign err           = err_q;
    assign rsp_rx        = rsp_rx_q;
    assign eng_start     = start_q;
    assign eng_bit_count = bit_count_q;
    assign eng_cpol      = mode_q[0];
    assign eng_cpha      = mode_q[1];
    assign eng_pfb       = mode_q[2];
    assign eng_tx_bits   = tx_q;

endmodule

// File: tb/tb_spi_engine_arbiter.sv
// Self-checking bench for spi_engine_arbiter: a loopback engine model plus a round-robin
// reference model drive directed and randomized transactions, invalid lengths, watchdog and reset.
module tb_spi_engine_arbiter;
    localparam int NREQ       = 4;
    localparam int MAX_BITS   = 1024;
    localparam int GAP_CYCLES = 4;
    localparam int TIMEOUT    = 4096;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NREQ-1:0]          req;
    logic [NREQ*16-1:0]       req_bits;
    logic [NREQ*3-1:0]        req_mode;
    logic [NREQ*MAX_BITS-1:0] req_tx;
    logic [NREQ-1:0]          gnt, ack, err;
    logic [MAX_BITS-1:0]      rsp_rx;
    logic                     eng_start;
    logic [15:0]              eng_bit_count;
    logic                     eng_cpol, eng_cpha, eng_pfb;
    logic [MAX_BITS-1:0]      eng_tx_bits;
    logic                     eng_busy, eng_done;
    logic [MAX_BITS-1:0]      eng_rx_bits;

    always #5 clk = ~clk;

    spi_engine_arbiter #(
        .NREQ(NREQ), .MAX_BITS(MAX_BITS), .GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_bits(req_bits), .req_mode(req_mode),
        .req_tx(req_tx), .gnt(gnt), .ack(ack), .err(err), .rsp_rx(rsp_rx),
        .eng_start(eng_start), .eng_bit_count(eng_bit_count), .eng_cpol(eng_cpol),
        .eng_cpha(eng_cpha), .eng_pfb(eng_pfb), .eng_tx_bits(eng_tx_bits),
        .eng_busy(eng_busy), .eng_done(eng_done), .eng_rx_bits(eng_rx_bits)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model state
    int                  model_ptr = 0;
    logic [15:0]         s_bits [NREQ];
    logic [2:0]          s_mode [NREQ];
    logic [MAX_BITS-1:0] s_tx   [NREQ];
    logic [MAX_BITS-1:0] exp_rsp = '0;
    int                  grant_log[$];
    int                  last_launch_ticks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_pick(input logic [NREQ-1:0] r);
        for (int i = 0; i < NREQ; i++)
            if (r[(model_ptr + i) % NREQ]) return (model_ptr + i) % NREQ;
        return -1;
    endfunction

    function automatic logic [MAX_BITS-1:0] mask(input int n);
        logic [MAX_BITS-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_BITS; i++) if (i < n) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [MAX_BITS-1:0] rand_tx();
        logic [MAX_BITS-1:0] v;
        for (int k = 0; k < MAX_BITS / 32; k++) v[32*k +: 32] = $urandom;
        return v;
    endfunction

    task automatic set_slice(input int i, input logic [15:0] b, input logic [2:0] m,
                             input logic [MAX_BITS-1:0] tx);
        s_bits[i] = b;
        s_mode[i] = m;
        s_tx[i]   = tx;
        req_bits[16*i +: 16]           = b;
        req_mode[3*i +: 3]             = m;
        req_tx[MAX_BITS*i +: MAX_BITS] = tx;
    endtask

    task automatic randomize_slices();
        for (int i = 0; i < NREQ; i++)
            set_slice(i, 16'($urandom_range(1, MAX_BITS)), 3'($urandom_range(0, 7)), rand_tx());
    endtask

    task automatic wait_launch(output bit seen);
        int t;
        seen = 1'b0;
        t    = 0;
        while (!seen && t < 20) begin
            tick();
            t++;
            seen = eng_start;
        end
        last_launch_ticks = t;
        check("launch_seen", 64'(seen), 64'(1));
    endtask

    task automatic wait_gnt_fall(output int gap);
        gap = 0;
        do begin
            tick();
            gap++;
        end while (gnt != '0 && gap < 50);
    endtask

    // One full transaction for the model's predicted winner with a loopback engine.
    task automatic do_txn(input int lat, input bit reraise, input bit scramble);
        int                  w;
        int                  gap;
        bit                  seen;
        logic [15:0]         b;
        logic [2:0]          m;
        logic [MAX_BITS-1:0] tx;
        w  = model_pick(req);
        b  = s_bits[w];
        m  = s_mode[w];
        tx = s_tx[w];
        wait_launch(seen);
        if (seen) begin
            grant_log.push_back(w);
            check("gnt_winner", 64'(gnt), 64'(1) << w);
            check("bit_count", 64'(eng_bit_count), 64'(b));
            check("mode", 64'({eng_pfb, eng_cpha, eng_cpol}), 64'(m));
            check("tx_latched", 64'(eng_tx_bits === tx), 64'(1));
            if (scramble)
                set_slice(w, 16'($urandom_range(1, MAX_BITS)), 3'($urandom_range(0, 7)), rand_tx());
            eng_busy = 1'b1;
            tick();
            check("start_pulse_drops", 64'(eng_start), 64'(0));
            repeat (lat) tick();
            eng_rx_bits = eng_tx_bits & mask(int'(eng_bit_count));
            eng_done    = 1'b1;
            tick();
            exp_rsp = tx & mask(int'(b));
            check("ack", 64'(ack), 64'(1) << w);
            check("no_err", 64'(err), 64'(0));
            check("rsp_rx", 64'(rsp_rx === exp_rsp), 64'(1));
            check("cfg_held", 64'(eng_bit_count), 64'(b));
            eng_done  = 1'b0;
            eng_busy  = 1'b0;
            req[w]    = 1'b0;
            model_ptr = (w + 1) % NREQ;
            tick();
            check("ack_one_cycle", 64'(ack), 64'(0));
            if (reraise) req[w] = 1'b1;
            wait_gnt_fall(gap);
            check("gnt_turnaround", 64'(gap + 1), 64'(GAP_CYCLES));
        end
    endtask

    task automatic serve_all();
        int guard;
        guard = 0;
        while (req != '0 && guard < 16) begin
            do_txn($urandom_range(0, 12), 1'b0, 1'b1);
            guard++;
        end
    endtask

    initial begin
        int  rr_exp [5];
        int  w, w2, t, gap;
        bit  seen, ack_seen, gnt_lost;

        rr_exp = '{0, 1, 2, 3, 0};
        rst_n = 1'b0;
        req = '0; req_bits = '0; req_mode = '0; req_tx = '0;
        eng_busy = 1'b0; eng_done = 1'b0; eng_rx_bits = '0;
        for (int i = 0; i < NREQ; i++) set_slice(i, 16'd0, 3'd0, '0);
        repeat (3) tick();

        check("rst_gnt", 64'(gnt), 64'(0));
        check("rst_ack", 64'(ack), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_start", 64'(eng_start), 64'(0));
        check("rst_bit_count", 64'(eng_bit_count), 64'(0));
        check("rst_mode", 64'({eng_pfb, eng_cpha, eng_cpol}), 64'(0));
        check("rst_tx_zero", 64'(eng_tx_bits == '0), 64'(1));
        check("rst_rsp_zero", 64'(rsp_rx == '0), 64'(1));
        rst_n = 1'b1;
        tick();
        check("idle_no_start", 64'(eng_start), 64'(0));

        // Round robin with all four requesters held
        randomize_slices();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) do_txn($urandom_range(0, 10), k < 4, 1'b1);
        check("rr_log_len", 64'(grant_log.size()), 64'(5));
        for (int k = 0; k < 5 && k < grant_log.size(); k++)
            check($sformatf("rr_order_%0d", k), 64'(grant_log[k]), 64'(rr_exp[k]));
        serve_all();

        // Directed 8-bit loopback on requester 2
        set_slice(2, 16'd8, 3'd0, MAX_BITS'(8'hA5));
        req = 4'b0100;
        do_txn(10, 1'b0, 1'b0);
        check("start_latency", 64'(last_launch_ticks), 64'(1));
        check("rsp_low_byte", 64'(rsp_rx[7:0]), 64'(8'hA5));

        // Maximum legal length
        randomize_slices();
        set_slice(1, 16'(MAX_BITS), 3'd5, rand_tx());
        req = 4'b0010;
        do_txn(3, 1'b0, 1'b1);

        // Randomized request patterns
        for (int r = 0; r < 6; r++) begin
            randomize_slices();
            req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            serve_all();
        end

        // Invalid lengths on requester 1: zero, then MAX_BITS+1
        set_slice(1, 16'd0, 3'd0, rand_tx());
        req = 4'b0010;
        tick();
        check("err_zero_len", 64'(err), 64'(4'b0010));
        check("no_start_zero", 64'(eng_start), 64'(0));
        check("no_gnt_zero", 64'(gnt), 64'(0));
        req = '0; model_ptr = 2;
        tick();
        check("err_single_pulse", 64'(err), 64'(0));
        set_slice(1, 16'(MAX_BITS + 1), 3'd0, rand_tx());
        req = 4'b0010;
        tick();
        check("err_too_long", 64'(err), 64'(4'b0010));
        check("no_start_long", 64'(eng_start), 64'(0));
        req = '0;
        tick();

        // Two invalid requests back to back, one per cycle
        set_slice(0, 16'd0, 3'd0, rand_tx());
        set_slice(3, 16'hFFFF, 3'd0, rand_tx());
        req = 4'b1001;
        w = model_pick(req);
        tick();
        check("err_first", 64'(err), 64'(1) << w);
        req[w] = 1'b0; model_ptr = (w + 1) % NREQ;
        w2 = model_pick(req);
        tick();
        check("err_second", 64'(err), 64'(1) << w2);
        req = '0; model_ptr = (w2 + 1) % NREQ;
        tick();
        check("err_burst_done", 64'(err), 64'(0));
        check("no_start_burst", 64'(eng_start), 64'(0));
        check("no_gnt_burst", 64'(gnt), 64'(0));

        // Done coincides with the last watchdog cycle: ack wins
        randomize_slices();
        req = 4'b1000;
        w = model_pick(req);
        wait_launch(seen);
        eng_busy = 1'b1;
        repeat (TIMEOUT - 1) tick();
        check("no_early_err", 64'(err), 64'(0));
        eng_rx_bits = eng_tx_bits & mask(int'(eng_bit_count));
        eng_done = 1'b1;
        tick();
        exp_rsp = s_tx[w] & mask(int'(s_bits[w]));
        check("coincide_ack", 64'(ack), 64'(1) << w);
        check("coincide_no_err", 64'(err), 64'(0));
        check("coincide_rsp", 64'(rsp_rx === exp_rsp), 64'(1));
        eng_done = 1'b0; eng_busy = 1'b0; req = '0; model_ptr = (w + 1) % NREQ;
        tick();
        check("coincide_no_late_err", 64'(err), 64'(0));
        wait_gnt_fall(gap);

        // Hung engine: watchdog err, grant held until busy falls
        randomize_slices();
        req = 4'b0100;
        w = model_pick(req);
        wait_launch(seen);
        eng_busy = 1'b1;
        t = 0; ack_seen = 1'b0;
        while (t < TIMEOUT + 20 && err == '0) begin
            tick();
            t++;
            ack_seen |= (ack != '0);
        end
        check("timeout_latency", 64'(t), 64'(TIMEOUT));
        check("timeout_err", 64'(err), 64'(1) << w);
        req = '0; model_ptr = (w + 1) % NREQ;
        gnt_lost = 1'b0;
        while (t < 5000) begin
            tick();
            t++;
            ack_seen |= (ack != '0);
            gnt_lost |= (gnt != (NREQ'(1) << w));
        end
        check("timeout_no_ack", 64'(ack_seen), 64'(0));
        check("timeout_gnt_held", 64'(gnt_lost), 64'(0));
        check("timeout_rsp_kept", 64'(rsp_rx === exp_rsp), 64'(1));
        eng_busy = 1'b0;
        wait_gnt_fall(gap);
        check("gnt_release_after_busy", 64'(gap), 64'(1));

        // Asynchronous reset in WAIT, then a fresh round starting at pointer 0
        randomize_slices();
        req = 4'b0010;
        wait_launch(seen);
        eng_busy = 1'b1;
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        eng_busy = 1'b0; req = '0;
        #1;
        check("arst_gnt", 64'(gnt), 64'(0));
        check("arst_start", 64'(eng_start), 64'(0));
        check("arst_bit_count", 64'(eng_bit_count), 64'(0));
        check("arst_mode", 64'({eng_pfb, eng_cpha, eng_cpol}), 64'(0));
        check("arst_tx_zero", 64'(eng_tx_bits == '0), 64'(1));
        check("arst_rsp_zero", 64'(rsp_rx == '0), 64'(1));
        model_ptr = 0; exp_rsp = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        req = 4'b1001;
        grant_log.delete();
        serve_all();
        check("post_reset_first", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
